// File: rtl/seq_detect_param.sv
// ----------------------------------------------------------------------------
// seq_detect_param
//
// Parametrised serial pattern detector. Bits arrive MSB-first on `in`, qualified
// by `in_valid`. When the last PAT_W accepted bits equal the stored pattern, a
// one-cycle `out` pulse is produced on the edge that samples the completing bit,
// and a saturating match counter increments on that same edge. The pattern
// defaults to RST_PAT and can be replaced at run time with `pat_load`.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   RST_PAT  pattern after reset, MSB is the first bit received
//   CNT_W    width of the match counter
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rstn       in   asynchronous active-low reset
//   clr        in   synchronous clear of history, fill, out and match_cnt
//   pat_load   in   load pat_in as the new pattern (history restarts)
//   pat_in     in   pattern to load, MSB first-received
//   overlap    in   1 = overlapping detection, 0 = non-overlapping
//   in_valid   in   in is sampled only while high
//   in         in   serial data bit
//   out        out  registered one-cycle match pulse
//   armed      out  high once PAT_W valid bits are held (DETECT state)
//   match_cnt  out  saturating number of matches
// ----------------------------------------------------------------------------
module seq_detect_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] RST_PAT = 4'b1011,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap,
   input  logic             in_valid,
   input  logic             in,
   output logic             out,
   output logic             armed,
   output logic [CNT_W-1:0] match_cnt
);

   // fill counts 0..PAT_W inclusive, so it needs one value beyond PAT_W-1
   localparam int               FW        = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {
      ST_FILL,
      ST_DETECT
   } state_t;

   state_t           state_reg,  state_next;
   logic [PAT_W-1:0] pat_reg,    pat_next;
   logic [PAT_W-1:0] hist_reg,   hist_next;
   logic [FW-1:0]    fill_reg,   fill_next;
   logic             out_reg,    out_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;

   // candidate values if the current bit is accepted
   logic [PAT_W-1:0] hist_shift;
   logic [FW-1:0]    fill_inc;
   logic             match;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ST_FILL;
         pat_reg   <= RST_PAT;
         hist_reg  <= '0;
         fill_reg  <= '0;
         out_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pat_reg   <= pat_next;
         hist_reg  <= hist_next;
         fill_reg  <= fill_next;
         out_reg   <= out_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      pat_next   = pat_reg;
      hist_next  = hist_reg;
      fill_next  = fill_reg;
      out_next   = 1'b0;
      cnt_next   = cnt_reg;

      hist_shift = {hist_reg[PAT_W-2:0], in};
      fill_inc   = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FW'(1);
      // a match needs a full window; a partial window padded with zeros must
      // not alias a pattern with leading zeros
      match      = (fill_inc == FILL_FULL) && (hist_shift == pat_reg);

      if (clr) begin
         hist_next = '0;
         fill_next = '0;
         cnt_next  = '0;
      end else if (pat_load) begin
         // the bit presented alongside a load is intentionally dropped
         pat_next  = pat_in;
         hist_next = '0;
         fill_next = '0;
      end else if (in_valid) begin
         if (match) begin
            out_next = 1'b1;
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
            if (overlap) begin
               // keep the window so trailing bits can start the next match
               hist_next = hist_shift;
               fill_next = FILL_FULL;
            end else begin
               hist_next = '0;
               fill_next = '0;
            end
         end else begin
            hist_next = hist_shift;
            fill_next = fill_inc;
         end
      end

      // state is a pure function of the fill level it will hold
      state_next = (fill_next == FILL_FULL) ? ST_DETECT : ST_FILL;
   end

   assign out       = out_reg;
   assign armed     = (state_reg == ST_DETECT);
   assign match_cnt = cnt_reg;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector for the lab's FSM experiments. It generalises the fixed 5-state "1011" Moore detector. The pattern and its length are set by parameters, and the pattern can be reloaded at run time. Input is qualified by a valid strobe, overlapping or non-overlapping detection is selectable, and a saturating match counter is provided. It sits between a debounced/serialised bit source and the board LEDs/seven-segment display.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- RST_PAT, 4'b1011, pattern after reset; MSB is the first bit received
- CNT_W, 8, width of match counter
- clk  input  1  clock, all logic rising-edge
- rstn  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of history, fill, out and match_cnt; pattern kept
- pat_load  input  1  synchronous load of pat_in as new pattern
- pat_in  input  PAT_W  pattern to load, MSB first-received
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- in_valid  input  1  in is sampled only when high
- in  input  1  serial data bit
- out  output  1  registered match pulse
- armed  output  1  high when PAT_W valid bits are held (state DETECT)
- match_cnt  output  CNT_W  number of matches, saturating

## Operation
- Internal registers:
  - pat[PAT_W-1:0]
  - hist[PAT_W-1:0]: newest bit in LSB
  - fill: 0..PAT_W, saturates at PAT_W
  - out
  - match_cnt
- States (derived from fill): FILL (fill<PAT_W), DETECT (fill==PAT_W); armed = (state==DETECT).
- Per-edge priority: clr > pat_load > sample. A lower-priority action in the same cycle is ignored.
- clr: hist=0, fill=0, out=0, match_cnt=0.
- pat_load:
  - pat=pat_in; hist=0, fill=0, out=0.
  - match_cnt is kept.
  - The in bit presented that cycle is dropped.
- Sample (in_valid=1, no clr/pat_load):
  - hist_n = {hist[PAT_W-2:0], in}
  - fill_n = min(fill+1, PAT_W)
  - match = (fill_n==PAT_W) && (hist_n==pat)
- On a sample with match=1:
  - out<=1.
  - match_cnt<=match_cnt+1, holding at 2^CNT_W-1.
  - overlap=1: hist<=hist_n, fill<=PAT_W. Trailing bits are reused.
  - overlap=0: hist<=0, fill<=0. The next match needs PAT_W fresh bits.
- On a sample with match=0: hist<=hist_n, fill<=fill_n, out<=0.
- in_valid=0 (no clr/pat_load): hist, fill and match_cnt hold; out<=0.
- overlap is read only on the matching edge. Changing it mid-stream affects only later matches.

## Timing
- Reset values (rstn low, asynchronous):
  - pat=RST_PAT
  - hist=0, fill=0
  - out=0, armed=0, match_cnt=0
- Latency: out rises on the same rising edge that samples the completing bit. It is high for exactly one clk cycle per match.
- Consecutive matches on back-to-back valid cycles (overlap=1, e.g. pattern all ones) keep out high continuously; match_cnt increments each edge.
- match_cnt updates on the same edge as out.
- armed updates on the edge that changes fill.
- rstn asserted mid-stream clears everything immediately, including a loaded pattern, which returns to RST_PAT.
- Release of rstn is synchronous to clk. The first sample is taken on the first edge with rstn high.

## Test plan
- Overlap: PAT_W=4, pattern 1011, overlap=1, valid bits 1,0,1,1,0,1,1 -> out pulses after bit 4 and after bit 7; match_cnt=2.
- Non-overlap: same stream with overlap=0 -> single pulse after bit 4; match_cnt=1; armed low after bit 4, high again after bit 8 if sent.
- Valid gaps: bits 1,0,1,1 with in_valid low for 3 cycles between each, and in toggled during the gaps -> exactly one pulse, on the edge sampling the 4th valid bit.
- Saturation: CNT_W=2, pattern 1111, overlap=1, seven consecutive valid 1s -> out high for 4 consecutive cycles; match_cnt stops at 3.
- Reload/clear priority:
  - pat_load with pat_in=0110 mid-stream -> fill=0; the next 0,1,1,0 gives one match.
  - clr and pat_load asserted together -> pattern unchanged; counter cleared.
- Reset mid-operation: after loading 0110 and sending 1,0,1, pulse rstn low -> out=0, match_cnt=0, armed=0, pattern back to 1011; then 1,0,1,1 -> one match.
